// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 RGB444 byte-stream source.
// Produces vsync/href/d frame timing and test patterns, clocked by pclk.
module ov7670_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern,
    input  logic [11:0] const_rgb,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int LINE_BYTES = 2 * (H_ACTIVE + H_BLANK);
    localparam int MAX_A      = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int MAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int BW         = $clog2(LINE_BYTES - 1) + 1;
    localparam int LW         = $clog2(MAX_LINES - 1) + 1;
    localparam int BAR_BYTES  = 2 * (H_ACTIVE / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t          state;
    state_t          nxt_state;
    logic [BW-1:0]   byte_cnt;
    logic [BW-1:0]   nxt_byte;
    logic [LW-1:0]   line_cnt;
    logic [LW-1:0]   nxt_line;
    logic [1:0]      pat_q;
    logic [11:0]     rgb_q;
    logic            byte_last;
    logic            line_last;
    logic            load;
    logic            nxt_href;
    logic            nxt_done;
    logic [7:0]      nxt_d;
    logic [7:0]      px;
    logic [3:0]      py;
    logic [2:0]      bar;
    logic [11:0]     rgb;

    always_comb begin
        nxt_state = state;
        nxt_byte  = byte_cnt;
        nxt_line  = line_cnt;
        byte_last = (byte_cnt == BW'(LINE_BYTES - 1));
        line_last = 1'b0;
        case (state)
            S_VSYNC:  line_last = (line_cnt == LW'(V_SYNC - 1));
            S_VBACK:  line_last = (line_cnt == LW'(V_BACK - 1));
            S_ACTIVE: line_last = (line_cnt == LW'(V_ACTIVE - 1));
            S_VFRONT: line_last = (line_cnt == LW'(V_FRONT - 1));
            default:  line_last = 1'b0;
        endcase
        if (state == S_IDLE) begin
            if (enable) begin
                nxt_state = S_VSYNC;
                nxt_byte  = '0;
                nxt_line  = '0;
            end
        end else if (!byte_last) begin
            nxt_byte = byte_cnt + 1'b1;
        end else begin
            nxt_byte = '0;
            if (!line_last) begin
                nxt_line = line_cnt + 1'b1;
            end else begin
                nxt_line = '0;
                case (state)
                    S_VSYNC:  nxt_state = S_VBACK;
                    S_VBACK:  nxt_state = S_ACTIVE;
                    S_ACTIVE: nxt_state = S_VFRONT;
                    default:  nxt_state = enable ? S_VSYNC : S_IDLE;
                endcase
            end
        end
    end

    // Pixel generation works on the upcoming position so outputs can be registered.
    always_comb begin
        load     = (nxt_state == S_VSYNC) && (state != S_VSYNC);
        px       = 8'(nxt_byte >> 1);
        py       = 4'(nxt_line);
        nxt_href = (nxt_state == S_ACTIVE) && (32'(nxt_byte) < 2 * H_ACTIVE);
        nxt_done = (nxt_state == S_VFRONT)
                && (nxt_line == LW'(V_FRONT - 1))
                && (nxt_byte == BW'(LINE_BYTES - 1));
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (32'(nxt_byte) >= k * BAR_BYTES) bar = 3'(k);
        end
        rgb = 12'h000;
        case (pat_q)
            2'd0: begin
                case (bar)
                    3'd0:    rgb = 12'hFFF;
                    3'd1:    rgb = 12'hFF0;
                    3'd2:    rgb = 12'h0FF;
                    3'd3:    rgb = 12'h0F0;
                    3'd4:    rgb = 12'hF0F;
                    3'd5:    rgb = 12'hF00;
                    3'd6:    rgb = 12'h00F;
                    default: rgb = 12'h000;
                endcase
            end
            2'd1:    rgb = {px[3:0], py, px[7:4]};
            2'd2:    rgb = (px[3] ^ py[3]) ? 12'hFFF : 12'h000;
            default: rgb = rgb_q;
        endcase
        nxt_d = 8'h00;
        if (nxt_href) nxt_d = nxt_byte[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            pat_q      <= 2'd0;
            rgb_q      <= 12'h000;
            vsync      <= 1'b0;
            href       <= 1'b0;
            d          <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
        end else begin
            state      <= nxt_state;
            byte_cnt   <= nxt_byte;
            line_cnt   <= nxt_line;
            vsync      <= (nxt_state == S_VSYNC);
            href       <= nxt_href;
            d          <= nxt_d;
            busy       <= (nxt_state != S_IDLE);
            frame_done <= nxt_done;
            if (nxt_done) frame_cnt <= frame_cnt + 8'd1;
            if (load) begin
                pat_q <= pattern;
                rgb_q <= const_rgb;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen with reduced frame geometry.
// Stimulus queues expected bytes/pixels; a monitor checks every output cycle.
module tb_ov7670_stream_gen;

    localparam int HA = 16;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int FULL = 2 * HA * VA;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  pattern = 2'd3;
    logic [11:0] const_rgb = 12'hABC;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q[$];
    logic [11:0] pix_q[$];
    int          addr_q[$];
    bit          lb_on = 1'b0;
    int          cap_writes = 0;

    logic [11:0] bars[8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};

    ov7670_stream_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS),
        .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) dut (
        .pclk(pclk), .rst(rst), .enable(enable),
        .pattern(pattern), .const_rgb(const_rgb),
        .vsync(vsync), .href(href), .d(d), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push_frame(input int p, input logic [11:0] c,
                              input bit lb, input int nbytes);
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] col;
        int          n;
        n = 0;
        for (int yi = 0; yi < VA; yi++) begin
            for (int xi = 0; xi < HA; xi++) begin
                x = 8'(xi);
                y = 8'(yi);
                case (p)
                    0:       col = bars[xi / (HA / 8)];
                    1:       col = {x[3:0], y[3:0], x[7:4]};
                    2:       col = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
                    default: col = c;
                endcase
                if (n < nbytes) exp_q.push_back({4'h0, col[11:8]});
                n++;
                if (n < nbytes) exp_q.push_back(col[7:0]);
                n++;
                if (lb) begin
                    pix_q.push_back(col);
                    addr_q.push_back(yi * HA + xi);
                end
            end
        end
    endtask

    // Monitor: byte scoreboard plus a capture-side pixel/address model.
    logic [3:0]  cap_lo;
    bit          cap_odd;
    int          cap_addr;
    logic [7:0]  e_byte;
    logic [11:0] e_pix;
    int          e_addr;

    always @(posedge pclk) begin
        #1;
        if (rst) begin
            cap_odd  = 1'b0;
            cap_addr = 0;
        end else begin
            if (vsync) begin
                cap_odd  = 1'b0;
                cap_addr = 0;
            end
            if (href) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got d=%0h with nothing expected", d);
                end else begin
                    e_byte = exp_q.pop_front();
                    chk("sb_data", 32'(d), 32'(e_byte));
                end
                if (lb_on) begin
                    if (!cap_odd) begin
                        cap_lo = d[3:0];
                    end else if (pix_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL lb_empty: got pixel %0h", {cap_lo, d});
                    end else begin
                        e_pix  = pix_q.pop_front();
                        e_addr = addr_q.pop_front();
                        chk("lb_pix", 32'({cap_lo, d}), 32'(e_pix));
                        chk("lb_addr", 32'(cap_addr), 32'(e_addr));
                        cap_addr++;
                        cap_writes++;
                    end
                    cap_odd = !cap_odd;
                end
            end else begin
                chk("d_idle", 32'(d), 32'h0);
            end
        end
    end

    // Called on the first VSYNC cycle; follows the frame until busy drops.
    task automatic measure_frame(input int exp_cnt);
        int  cnt;
        int  lines;
        int  dones;
        bit  prev;
        cnt = 0;
        while (vsync && cnt < 2000) begin cnt++; tick(); end
        chk("vsync_len", 32'(cnt), 32'd40);
        cnt = 0;
        while (!href && cnt < 2000) begin cnt++; tick(); end
        chk("vback_gap", 32'(cnt), 32'd80);
        cnt = 0;
        while (href && cnt < 2000) begin cnt++; tick(); end
        chk("href_len", 32'(cnt), 32'd32);
        lines = 1;
        dones = 0;
        prev  = 1'b0;
        for (int i = 0; i < 2000 && busy; i++) begin
            tick();
            if (href && !prev) lines++;
            prev = href;
            if (frame_done) dones++;
        end
        chk("href_lines", 32'(lines), 32'd4);
        chk("done_pulses", 32'(dones), 32'd1);
        chk("fr_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("fr_busy", 32'(busy), 32'd0);
        chk("fr_sb_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && !frame_done; i++) tick();
        chk(name, 32'(frame_done), 32'd1);
    endtask

    initial begin
        int dn;
        repeat (3) tick();
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_href", 32'(href), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_vsync", 32'(vsync), 32'd1);
        chk("rel_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        enable = 1'b0;
        #1;
        chk("rst_async_vsync", 32'(vsync), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        push_frame(3, 12'hABC, 1'b0, FULL);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        measure_frame(1);

        push_frame(0, 12'h000, 1'b0, FULL);
        pattern = 2'd0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        pattern = 2'd3;
        const_rgb = 12'h123;
        measure_frame(2);

        pattern = 2'd2;
        push_frame(2, 12'h000, 1'b0, FULL);
        enable = 1'b1;
        tick();
        for (int f = 0; f < 255; f++) begin
            if (f < 254) push_frame(2, 12'h000, 1'b0, FULL);
            else enable = 1'b0;
            wait_done("b2b_done");
            tick();
            if (f < 254) begin
                chk("b2b_vsync", 32'(vsync), 32'd1);
            end else begin
                chk("stop_vsync", 32'(vsync), 32'd0);
                chk("stop_busy", 32'(busy), 32'd0);
            end
        end
        chk("wrap_cnt", 32'(frame_cnt), 32'd1);
        chk("b2b_sb_left", 32'(exp_q.size()), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pattern = 2'd3;
        const_rgb = 12'h5A7;
        push_frame(3, 12'h5A7, 1'b0, 75);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (209) tick();
        @(posedge pclk);
        #3;
        chk("pre_rst_href", 32'(href), 32'd1);
        chk("pre_rst_d", 32'(d), 32'h05);
        rst = 1'b1;
        #1;
        chk("mid_rst_vsync", 32'(vsync), 32'd0);
        chk("mid_rst_href", 32'(href), 32'd0);
        chk("mid_rst_d", 32'(d), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        dn = 0;
        repeat (400) begin
            tick();
            if (frame_done) dn++;
        end
        chk("rst_no_done", 32'(dn), 32'd0);
        chk("rst_cnt_kept", 32'(frame_cnt), 32'd0);
        chk("rst_sb_left", 32'(exp_q.size()), 32'd0);

        lb_on = 1'b1;
        cap_writes = 0;
        push_frame(1, 12'h000, 1'b1, FULL);
        pattern = 2'd1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        measure_frame(1);
        chk("lb_writes", 32'(cap_writes), 32'd64);
        chk("lb_left", 32'(pix_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
